shift_reg_loader: RTL and testbench
===================================

// Module: shift_reg_loader
// PURPOSE
//  Downstream consumer of register_mux register writes. Takes one DATA_WIDTH word per
//  valid/ready handshake and shifts it serially into an external shift-register chain
//  (DAC/gain/threshold control on the board) via sclk/sdata. It then pulses latch to
//  transfer the chain contents. Sits between the AXI4-Lite register bank and board pins.
// PARAMETERS
//  DATA_WIDTH    32  bits per word shifted out (>=2)
//  CLK_DIV       4   ACLK cycles per sclk half-period (>=1)
//  MSB_FIRST     1   1: bit DATA_WIDTH-1 shifted first; 0: bit 0 first
//  LATCH_CYCLES  2   ACLK cycles latch held high after last bit (>=1)
// PORTS
//  ACLK          in   1           single clock; all logic rising-edge
//  ARESETN       in   1           reset, asynchronous assert, active-low
//  load_data     in   DATA_WIDTH  word to shift, sampled on handshake
//  load_valid    in   1           producer has a word
//  load_ready    out  1           block can accept (high only in IDLE)
//  busy          out  1           shifting or latching in progress
//  done          out  1           one-cycle pulse: word shifted and latched
//  last_word     out  DATA_WIDTH  copy of most recently completed word (readback)
//  sclk          out  1           serial clock to chain, idles low
//  sdata         out  1           serial data, changes only while sclk low
//  latch         out  1           chain latch strobe, active-high
// BEHAVIOUR
//  - All outputs registered. Reset values: load_ready=1, busy=0, done=0, last_word=0,
//    sclk=0, sdata=0, latch=0. Reset forces IDLE from any state.
//  - Mid-operation reset abandons the partial word: no latch, no done, last_word=0.
//  - FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LATCH) -> IDLE.
//  - IDLE: handshake = load_valid & load_ready at edge T. Capture load_data into shreg.
//    Clear bit counter and divider, go SHIFT_LO.
//    load_valid while not ready is ignored; the producer holds data until ready.
//  - SHIFT_LO (CLK_DIV cycles): sclk=0, sdata = current bit (MSB or LSB of shreg
//    per MSB_FIRST). sdata is set on entry and stable for the whole bit.
//  - SHIFT_HI (CLK_DIV cycles): sclk=1, sdata unchanged. On exit, shift shreg and
//    increment bit counter.
//    bit counter == DATA_WIDTH-1 on exit -> LATCH, else -> SHIFT_LO.
//  - LATCH (LATCH_CYCLES cycles): sclk=0, sdata=0, latch=1; on exit last_word <= word,
//    done=1 for one cycle, load_ready=1, busy=0.
//  - Timing (handshake edge T): first bit on sdata from T+1.
//    sclk rises at T+1+CLK_DIV and every 2*CLK_DIV after, DATA_WIDTH rising edges total.
//    latch high T+1+2*DATA_WIDTH*CLK_DIV .. +LATCH_CYCLES-1.
//    done at cycle T+1+2*DATA_WIDTH*CLK_DIV+LATCH_CYCLES.
//  - Back-to-back: load_ready is high in the done cycle, so a word accepted there starts
//    the next transfer with no extra idle cycle. sclk stays low at least CLK_DIV+LATCH_CYCLES.
//  - Counters: divider width clog2(CLK_DIV+1); bit counter clog2(DATA_WIDTH);
//    latch counter clog2(LATCH_CYCLES+1); no wrap is reachable in legal operation.
//  - busy = ~load_ready at all times.
// STRUCTURE
//  - Package shift_loader_pkg: state enum typedef (IDLE,SHIFT_LO,SHIFT_HI,LATCH),
//    default-parameter constants, and a width helper for counter sizing.
//  - Sub-module shift_tick_gen: CLK_DIV divider, cleared on state change, emits a
//    one-cycle tick at the end of each half-period; the FSM advances only on tick.
//  - Top: FSM, shreg, bit/latch counters, output registers.
// TESTING (defaults DATA_WIDTH=32, CLK_DIV=4, LATCH_CYCLES=2)
//  - Reset: hold ARESETN=0, pulse load_valid -> all outputs at reset values, no sclk edge.
//  - Single word 0xA5C3_0001 (MSB_FIRST=1), handshake at T -> 32 sclk rises, sampled
//    sdata on each rise = 1,0,1,0,0,1,0,1...1.
//    latch high at T+257..T+258, done at T+259, last_word=0xA5C3_0001.
//  - Ready/busy: load_valid held with new data during transfer -> not accepted until
//    done cycle. Two words back-to-back -> second handshake at T+259, its done at T+518.
//  - MSB_FIRST=0 with 0x0000_0001 -> only first sampled bit 1; CLK_DIV=1 -> done at T+67.
//  - Reset mid-shift (after bit 10) -> sclk/latch/done stay 0, load_ready=1 one edge after
//    release; a fresh word then completes normally.
//  - Checker: sdata never changes while sclk=1; latch never high while sclk=1.

Source files
------------

// File: rtl/shift_loader_pkg.sv
// Shared types and sizing helpers for the serial shift-register loader.
// Holds the FSM state encoding, default parameter values and the counter-width helper.
package shift_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_MSB_FIRST    = 1;
  localparam int DEF_LATCH_CYCLES = 2;

  // Bits needed for a counter sized by clog2(maxVal), never narrower than one bit.
  function automatic int cnt_width(input int maxVal);
    int w;
    w = $clog2(maxVal);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Half-period divider for the serial clock: emits a one-cycle tick every CLK_DIV
// cycles, restarting from zero whenever the owning FSM requests a clear.
module shift_tick_gen
  import shift_loader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = cnt_width(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] divCnt_q;
  logic [CNT_W-1:0] divCnt_d;

  assign tick_o = (divCnt_q == CNT_LAST);

  // The count restarts after every tick so each half-period is exactly CLK_DIV cycles.
  always_comb begin
    divCnt_d = divCnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      divCnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_d;
    end
  end

endmodule

// File: rtl/shift_reg_loader.sv
// Accepts one word per valid/ready handshake, shifts it serially into an external
// shift-register chain on sclk/sdata, then strobes latch and reports done.
module shift_reg_loader
  import shift_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int MSB_FIRST    = DEF_MSB_FIRST,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] last_word,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  latch
);

  localparam int BIT_W = cnt_width(DATA_WIDTH);
  localparam int LAT_W = cnt_width(LATCH_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]        bitCnt_q, bitCnt_d;
  logic [LAT_W-1:0]        latCnt_q, latCnt_d;
  logic [DATA_WIDTH-1:0]   lastWord_q, lastWord_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sclk_q, sclk_d;
  logic                    sdata_q, sdata_d;
  logic                    latch_q, latch_d;

  logic                    tick;
  logic                    divClear;
  logic [DATA_WIDTH-1:0]   shregRot;
  logic                    loadBit;
  logic                    nextBit;

  // The word is rotated rather than shifted, so after DATA_WIDTH bits shreg holds
  // the original word again and doubles as the readback copy.
  assign shregRot = (MSB_FIRST != 0) ? {shreg_q[DATA_WIDTH-2:0], shreg_q[DATA_WIDTH-1]}
                                     : {shreg_q[0], shreg_q[DATA_WIDTH-1:1]};
  assign loadBit  = (MSB_FIRST != 0) ? load_data[DATA_WIDTH-1] : load_data[0];
  assign nextBit  = (MSB_FIRST != 0) ? shregRot[DATA_WIDTH-1] : shregRot[0];

  assign divClear = (state_q == IDLE) || (state_q == LATCH) || (state_d != state_q);

  shift_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .clear_i(divClear),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitCnt_d   = bitCnt_q;
    latCnt_d   = latCnt_q;
    lastWord_d = lastWord_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    latch_d    = latch_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        if (load_valid && ready_q) begin
          state_d  = SHIFT_LO;
          shreg_d  = load_data;
          bitCnt_d = '0;
          sdata_d  = loadBit;
          ready_d  = 1'b0;
        end
      end

      SHIFT_LO: begin
        sclk_d = 1'b0;
        if (tick) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end

      SHIFT_HI: begin
        if (tick) begin
          shreg_d = shregRot;
          sclk_d  = 1'b0;
          if (bitCnt_q == BIT_LAST) begin
            state_d  = LATCH;
            sdata_d  = 1'b0;
            latch_d  = 1'b1;
            latCnt_d = '0;
          end else begin
            state_d  = SHIFT_LO;
            bitCnt_d = bitCnt_q + BIT_W'(1);
            sdata_d  = nextBit;
          end
        end
      end

      LATCH: begin
        if (latCnt_q == LAT_LAST) begin
          state_d    = IDLE;
          latch_d    = 1'b0;
          done_d     = 1'b1;
          ready_d    = 1'b1;
          lastWord_d = shreg_q;
        end else begin
          latCnt_d = latCnt_q + LAT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
      end
    endcase

    busy_d = ~ready_d;
  end

  // Reset drops any partial word: no latch, no done, readback cleared.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitCnt_q   <= '0;
      latCnt_q   <= '0;
      lastWord_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitCnt_q   <= bitCnt_d;
      latCnt_q   <= latCnt_d;
      lastWord_q <= lastWord_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      latch_q    <= latch_d;
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign last_word  = lastWord_q;
  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign latch      = latch_q;

endmodule

// File: tb/tb_shift_reg_loader.sv
// Bench for shift_reg_loader: two instances (MSB-first/CLK_DIV=4 and LSB-first/CLK_DIV=1)
// checked against expected bit order and cycle timing derived from the transfer rules.
module tb_shift_reg_loader;

  localparam int DW    = 32;
  localparam int LATCH = 2;

  logic        ACLK;
  logic        ARESETN;

  logic [31:0] aData, aLast;
  logic        aValid, aReady, aBusy, aDone, aSclk, aSdata, aLatch;
  logic [31:0] bData, bLast;
  logic        bValid, bReady, bBusy, bDone, bSclk, bSdata, bLatch;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          useB = 1'b0;
  logic        oReady, oBusy, oDone, oSclk, oSdata, oLatch;
  logic [31:0] oLast;

  int   violA = 0, violB = 0, risesA = 0;
  logic pSclkA = 1'b0, pSdataA = 1'b0, pSclkB = 1'b0, pSdataB = 1'b0;

  shift_reg_loader #(
    .DATA_WIDTH(32), .CLK_DIV(4), .MSB_FIRST(1), .LATCH_CYCLES(2)
  ) dutA (
    .ACLK(ACLK), .ARESETN(ARESETN), .load_data(aData), .load_valid(aValid),
    .load_ready(aReady), .busy(aBusy), .done(aDone), .last_word(aLast),
    .sclk(aSclk), .sdata(aSdata), .latch(aLatch)
  );

  shift_reg_loader #(
    .DATA_WIDTH(32), .CLK_DIV(1), .MSB_FIRST(0), .LATCH_CYCLES(2)
  ) dutB (
    .ACLK(ACLK), .ARESETN(ARESETN), .load_data(bData), .load_valid(bValid),
    .load_ready(bReady), .busy(bBusy), .done(bDone), .last_word(bLast),
    .sclk(bSclk), .sdata(bSdata), .latch(bLatch)
  );

  assign oReady = useB ? bReady : aReady;
  assign oBusy  = useB ? bBusy  : aBusy;
  assign oDone  = useB ? bDone  : aDone;
  assign oSclk  = useB ? bSclk  : aSclk;
  assign oSdata = useB ? bSdata : aSdata;
  assign oLatch = useB ? bLatch : aLatch;
  assign oLast  = useB ? bLast  : aLast;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  // Serial protocol watch: data must hold while sclk is high, latch never overlaps sclk.
  always @(negedge ACLK) begin
    if (pSclkA && aSclk && (aSdata !== pSdataA)) violA++;
    if (aLatch && aSclk) violA++;
    if (aSclk && !pSclkA) risesA++;
    if (pSclkB && bSclk && (bSdata !== pSdataB)) violB++;
    if (bLatch && bSclk) violB++;
    pSclkA  = aSclk;
    pSdataA = aSdata;
    pSclkB  = bSclk;
    pSdataB = bSdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  function automatic logic expBit(input logic [31:0] w, input int idx, input bit msb);
    return msb ? w[31-idx] : w[idx];
  endfunction

  // Offers a word, then follows the whole transfer from the handshake edge onward.
  task automatic applyStimulus(input bit selB, input logic [31:0] word, input bit chain,
                               input logic [31:0] nextWord, output int hsCyc);
    int clkDiv, n, rises, firstRise, latchFirst, latchCnt, doneN, bitErr, busyErr, limit;
    bit msb;
    logic prevSclk, doneReady, doneBusy;
    logic [31:0] doneLast;
    useB   = selB;
    clkDiv = selB ? 1 : 4;
    msb    = selB ? 1'b0 : 1'b1;
    if (selB) begin bData = word; bValid = 1'b1; end
    else      begin aData = word; aValid = 1'b1; end
    n = 0;
    while (oReady !== 1'b1 && n < 600) begin
      @(posedge ACLK); #1; n++;
    end
    checkOutput("readyBeforeHs", {31'd0, oReady}, 32'd1);
    @(posedge ACLK); #1;
    hsCyc = cyc;
    if (chain) begin
      if (selB) bData = nextWord; else aData = nextWord;
    end else begin
      if (selB) bValid = 1'b0; else aValid = 1'b0;
    end
    checkOutput("firstBit", {31'd0, oSdata}, {31'd0, expBit(word, 0, msb)});
    rises = 0; firstRise = -1; latchFirst = -1; latchCnt = 0; doneN = -1;
    bitErr = 0; busyErr = 0; prevSclk = 1'b0;
    doneReady = 1'b0; doneBusy = 1'b1; doneLast = '0;
    limit = 2 * DW * clkDiv + LATCH + 20;
    for (n = 0; n < limit; n++) begin
      if (n > 0) begin @(posedge ACLK); #1; end
      if (oDone === 1'b1) begin
        doneN = n; doneReady = oReady; doneBusy = oBusy; doneLast = oLast;
        break;
      end
      if (oBusy !== 1'b1 || oReady !== 1'b0) busyErr++;
      if (oSclk === 1'b1 && prevSclk === 1'b0) begin
        if (firstRise < 0) firstRise = n;
        if (rises < DW && oSdata !== expBit(word, rises, msb)) bitErr++;
        rises++;
      end
      if (oLatch === 1'b1) begin
        if (latchFirst < 0) latchFirst = n;
        latchCnt++;
      end
      prevSclk = oSclk;
    end
    checkOutput("sclkRises",   rises,      DW);
    checkOutput("bitOrder",    bitErr,     0);
    checkOutput("firstRise",   firstRise,  clkDiv);
    checkOutput("latchStart",  latchFirst, 2 * DW * clkDiv);
    checkOutput("latchLen",    latchCnt,   LATCH);
    checkOutput("doneCycle",   doneN,      2 * DW * clkDiv + LATCH);
    checkOutput("busyDuring",  busyErr,    0);
    checkOutput("readyAtDone", {31'd0, doneReady}, 32'd1);
    checkOutput("busyAtDone",  {31'd0, doneBusy},  32'd0);
    checkOutput("lastWord",    doneLast,   word);
  endtask

  initial begin
    int t1, t2, t3, guard, snap, badIdle;
    logic [31:0] w;
    ARESETN = 1'b0;
    aValid = 1'b0; bValid = 1'b0; aData = '0; bData = '0;

    // Reset holds everything quiet even with load_valid pulsing.
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      aValid = ~aValid; bValid = ~bValid; aData = $urandom; bData = $urandom;
    end
    checkOutput("rstReady", {31'd0, aReady}, 32'd1);
    checkOutput("rstBusy",  {31'd0, aBusy},  32'd0);
    checkOutput("rstDone",  {31'd0, aDone},  32'd0);
    checkOutput("rstLast",  aLast, 32'd0);
    checkOutput("rstSclk",  {31'd0, aSclk},  32'd0);
    checkOutput("rstSdata", {31'd0, aSdata}, 32'd0);
    checkOutput("rstLatch", {31'd0, aLatch}, 32'd0);
    checkOutput("rstReadyB", {31'd0, bReady}, 32'd1);
    checkOutput("rstNoSclk", risesA, 0);
    aValid = 1'b0; bValid = 1'b0;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Fixed word with a second word held on the bus during the transfer.
    applyStimulus(1'b0, 32'hA5C3_0001, 1'b1, 32'h3C96_F00D, t1);
    applyStimulus(1'b0, 32'h3C96_F00D, 1'b0, 32'h0, t2);
    checkOutput("backToBack", t2 - t1, 2 * DW * 4 + LATCH + 1);

    // LSB-first instance with fast divider.
    applyStimulus(1'b1, 32'h0000_0001, 1'b0, 32'h0, t3);
    applyStimulus(1'b1, $urandom, 1'b0, 32'h0, t3);

    // Random words on the MSB-first instance, chained.
    w = $urandom;
    applyStimulus(1'b0, $urandom, 1'b1, w, t1);
    applyStimulus(1'b0, w, 1'b0, 32'h0, t2);
    checkOutput("backToBackRnd", t2 - t1, 2 * DW * 4 + LATCH + 1);

    // Abort a transfer after bit 10 with reset.
    useB = 1'b0;
    aData = $urandom; aValid = 1'b1;
    @(posedge ACLK); #1;
    aValid = 1'b0;
    snap = risesA;
    guard = 0;
    while (risesA - snap < 11 && guard < 200) begin
      @(posedge ACLK); #1; guard++;
    end
    checkOutput("midRiseCount", risesA - snap, 11);
    ARESETN = 1'b0;
    #1;
    checkOutput("midRstSclk",  {31'd0, aSclk},  32'd0);
    checkOutput("midRstLatch", {31'd0, aLatch}, 32'd0);
    checkOutput("midRstDone",  {31'd0, aDone},  32'd0);
    checkOutput("midRstLast",  aLast, 32'd0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("postRstReady", {31'd0, aReady}, 32'd1);
    checkOutput("postRstBusy",  {31'd0, aBusy},  32'd0);
    snap = risesA;
    badIdle = 0;
    for (int i = 0; i < 20; i++) begin
      if (aLatch !== 1'b0 || aDone !== 1'b0 || aSclk !== 1'b0) badIdle++;
      @(posedge ACLK); #1;
    end
    checkOutput("postRstQuiet", badIdle, 0);
    checkOutput("postRstNoSclk", risesA - snap, 0);
    checkOutput("postRstLast", aLast, 32'd0);
    applyStimulus(1'b0, $urandom, 1'b0, 32'h0, t1);

    checkOutput("protocolA", violA, 0);
    checkOutput("protocolB", violB, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
